// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide.
// Latency: 33 cycles from accepted iStart to the oDone cycle, identical for all ops.
// Backpressure: oBusy is high while an op runs; iStart is ignored unless IDLE.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iStart,
  input  logic [4:0]      iControlSignal,
  input  logic [XLEN-1:0] iA,
  input  logic [XLEN-1:0] iB,
  output logic            oBusy,
  output logic            oDone,
  output logic [XLEN-1:0] oResult
);

  // Shared ALU control codes for the M-extension operations
  localparam logic [4:0] OPMUL    = 5'd16;
  localparam logic [4:0] OPMULH   = 5'd17;
  localparam logic [4:0] OPMULHSU = 5'd18;
  localparam logic [4:0] OPMULHU  = 5'd19;
  localparam logic [4:0] OPDIV    = 5'd20;
  localparam logic [4:0] OPDIVU   = 5'd21;
  localparam logic [4:0] OPREM    = 5'd22;
  localparam logic [4:0] OPREMU   = 5'd23;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  op_q, op_d;
  logic [31:0] hi_q, hi_d;      // mul: upper product half; div: partial remainder
  logic [31:0] lo_q, lo_d;      // mul: multiplier/lower half; div: dividend/quotient
  logic [31:0] opnd_q, opnd_d;  // mul: multiplicand magnitude; div: divisor magnitude
  logic        neg_q, neg_d;    // product / quotient negated in FIX
  logic        rneg_q, rneg_d;  // remainder negated in FIX (dividend negative)
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;

  logic        start_is_m, start_is_div, sgn_a_en, sgn_b_en;
  logic        sa, sb;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic [63:0] prod, prod_s;
  logic [31:0] quo_s, rem_s;
  logic [31:0] fix_result;

  // Decode the incoming op: is it an M op, is it a divide, which operands are signed
  always_comb begin
    start_is_m   = 1'b1;
    start_is_div = 1'b0;
    sgn_a_en     = 1'b0;
    sgn_b_en     = 1'b0;
    case (iControlSignal)
      OPMUL:    ;
      OPMULH:   begin sgn_a_en = 1'b1; sgn_b_en = 1'b1; end
      OPMULHSU: sgn_a_en = 1'b1;
      OPMULHU:  ;
      OPDIV, OPREM: begin start_is_div = 1'b1; sgn_a_en = 1'b1; sgn_b_en = 1'b1; end
      OPDIVU, OPREMU: start_is_div = 1'b1;
      default:  start_is_m = 1'b0;
    endcase
  end

  // Operand signs and magnitudes; |0x80000000| wraps to 0x80000000 as unsigned
  always_comb begin
    sa    = sgn_a_en & iA[31];
    sb    = sgn_b_en & iB[31];
    mag_a = sa ? (~iA + 32'd1) : iA;
    mag_b = sb ? (~iB + 32'd1) : iB;
  end

  // One iteration step of each algorithm, selected by the latched op in CALC
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : 33'd0);
    div_shift = {hi_q, lo_q[31]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
  end

  // Sign fix-up and special cases applied once in FIX
  always_comb begin
    prod   = {hi_q, lo_q};
    prod_s = neg_q ? (~prod + 64'd1) : prod;
    // Divide by zero: quotient forced to all ones. The remainder needs no forcing:
    // with a zero divisor every step keeps the shifted value, so it ends as |iA|
    // and the dividend-sign fix-up restores the original iA.
    quo_s  = (opnd_q == 32'd0) ? 32'hFFFF_FFFF : (neg_q ? (~lo_q + 32'd1) : lo_q);
    rem_s  = rneg_q ? (~hi_q + 32'd1) : hi_q;
    case (op_q)
      OPMUL:                      fix_result = prod_s[31:0];
      OPMULH, OPMULHSU, OPMULHU:  fix_result = prod_s[63:32];
      OPDIV, OPDIVU:              fix_result = quo_s;
      OPREM, OPREMU:              fix_result = rem_s;
      default:                    fix_result = 32'd0;
    endcase
  end

  // Next-state and datapath update for IDLE -> CALC x32 -> FIX -> IDLE
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (iStart && start_is_m) begin
          state_d = S_CALC;
          cnt_d   = 5'd31;
          op_d    = iControlSignal;
          busy_d  = 1'b1;
          hi_d    = 32'd0;
          neg_d   = sa ^ sb;
          rneg_d  = sa;
          if (start_is_div) begin
            lo_d   = mag_a;
            opnd_d = mag_b;
          end else begin
            lo_d   = mag_b;
            opnd_d = mag_a;
          end
        end
      end
      S_CALC: begin
        if (op_q == OPDIV || op_q == OPDIVU || op_q == OPREM || op_q == OPREMU) begin
          if (!div_diff[33]) begin
            hi_d = div_diff[31:0];
            lo_d = {lo_q[30:0], 1'b1};
          end else begin
            hi_d = div_shift[31:0];
            lo_d = {lo_q[30:0], 1'b0};
          end
        end else begin
          hi_d = mul_sum[32:1];
          lo_d = {mul_sum[0], lo_q[31:1]};
        end
        if (cnt_q == 5'd0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_FIX: begin
        state_d  = S_IDLE;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        result_d = fix_result;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any op in flight
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      op_q     <= 5'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      opnd_q   <= 32'd0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign oBusy   = busy_q;
  assign oDone   = done_q;
  assign oResult = result_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage, directly downstream of ALU control. Consumes the same 5-bit ALU control code the ALU receives. Executes the eight M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) over multiple cycles with a start/busy/done handshake. The hazard unit holds the pipeline while `oBusy` is high; the single-cycle ALU keeps all other operations.

## Interface

Parameters:
- `XLEN`, 32: operand and result width. Only 32 is supported.

Ports:
- `iCLK`  in  1  clock. All state changes on the rising edge.
- `iRST`  in  1  reset. Asynchronous, active-high.
- `iStart`  in  1  request to begin an operation. Sampled only in IDLE.
- `iControlSignal`  in  5  ALU control code (OPMUL, OPMULH, OPMULHSU, OPMULHU, OPDIV, OPDIVU, OPREM, OPREMU, from the shared parameter include).
- `iA`  in  32  rs1 operand. Sampled with `iStart`.
- `iB`  in  32  rs2 operand. Sampled with `iStart`.
- `oBusy`  out  1  operation in progress.
- `oDone`  out  1  one-cycle pulse; `oResult` is valid in the same cycle.
- `oResult`  out  32  last completed result. Held until the next completion.

## Operation

States and transitions:
- IDLE -> CALC on `iStart`=1 with an M code.
  - Latches the op.
  - Latches operand magnitudes.
  - Latches the sign flags.
  - Counter=31.
- CALC -> CALC while counter≠0; the counter decrements each cycle.
- CALC -> FIX when counter=0.
- FIX -> IDLE unconditionally.
  - Writes `oResult`.
  - Pulses `oDone`.

Start acceptance:
- `iStart` with a non-M code is ignored; the unit stays in IDLE.
- `iStart` outside IDLE is ignored.

Operand signedness:
- MULH: both operands signed.
- MULHSU: `iA` signed, `iB` unsigned.
- MULHU: both unsigned.
- MUL: sign-agnostic; treated as unsigned.
- DIV, REM: both signed.
- DIVU, REMU: both unsigned.
- A signed operand's magnitude is its two's-complement absolute value as 32-bit unsigned; |0x80000000| = 0x80000000.

Multiply:
- Radix-2 shift-add, one multiplier bit per CALC cycle, 64-bit unsigned accumulator.
- FIX negates the 64-bit product when the operand signs differ.
- MUL returns bits [31:0]; MULH, MULHSU and MULHU return bits [63:32].

Divide:
- Restoring divide, one quotient bit per CALC cycle, 33-bit partial remainder.
- FIX negates the quotient when the operand signs differ.
- FIX negates the remainder when the dividend is negative.

Divide special cases, forced in FIX:
- Divisor = 0:
  - DIV and DIVU return 0xFFFFFFFF.
  - REM and REMU return the original `iA`.
- Signed overflow (0x80000000 / 0xFFFFFFFF):
  - DIV returns 0x80000000.
  - REM returns 0.
  - This falls out of the magnitude path and must not be special-cased incorrectly.

Reset (`iRST`=1, at any time):
- State goes to IDLE.
- `oBusy`=0, `oDone`=0, `oResult`=0.
- Counter and all datapath registers are cleared.
- Reset mid-operation aborts the operation: no `oDone` pulse, and `oResult` stays 0.

## Timing

- Let E0 be the edge where `iStart` is accepted.
- `oBusy` rises after E0 and stays high through CALC (edges E1..E32) and FIX.
- FIX occupies the cycle after E32.
- At E33 the unit returns to IDLE, `oBusy` falls, and `oDone` and `oResult` become valid for one cycle.
- Latency is 33 cycles from acceptance to the `oDone` cycle, identical for all eight ops, including the special cases.
- Back-to-back operation: a new `iStart` sampled at E34, the edge ending the `oDone` cycle, is accepted. Throughput is one op per 34 cycles.
- `iA`, `iB` and `iControlSignal` may change freely after E0.
- `oDone` is never high for more than one cycle per operation.

## Test plan

- MUL 0x00000007 × 0xFFFFFFFD, then MULH, MULHSU and MULHU on the same operands. Required results:
  - MUL: 0xFFFFFFEB.
  - MULH: 0xFFFFFFFF.
  - MULHSU: 0x00000006.
  - MULHU: 0x00000006.
  - Each result arrives with `oDone` exactly 33 cycles after acceptance.
- DIV and REM of 0xFFFFFFF9 (-7) by 2 -> 0xFFFFFFFD and 0xFFFFFFFF. DIVU and REMU on the same operands -> 0x7FFFFFFC and 0x00000001.
- Divide by zero, `iA`=0x80000001:
  - DIV and DIVU -> 0xFFFFFFFF.
  - REM and REMU -> 0x80000001.
- Signed overflow 0x80000000 / 0xFFFFFFFF: DIV -> 0x80000000, REM -> 0.
- Handshake corners:
  - `iStart` held high for 40 cycles -> exactly one op is accepted at E0, and a second is accepted at E34.
  - `iStart` with the OPADD code -> `oBusy` stays 0.
- Assert `iRST` at cycle 10 of a DIV:
  - All outputs go to 0 immediately (asynchronously).
  - No `oDone` pulse occurs.
  - The next `iStart` after reset release completes normally.
